// File: rtl/memif_pkg.sv
// memif_pkg: shared definitions for the memif_stream bridge.
//   - Chunk tag constants used by the packet codec.
//   - Controller state encoding.
`timescale 1ns/1ps
package memif_pkg;

  // Chunk tags: the first data chunk, every later chunk, and the header's first chunk.
  localparam logic [1:0] TAG_FIRST = 2'b01;
  localparam logic [1:0] TAG_REST  = 2'b10;
  localparam logic [1:0] TAG_HDR   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    LOAD,
    STREAM
  } state_t;

endpackage

// File: rtl/memif_packet_codec.sv
// memif_packet_codec: combinational framing/unframing of tagged packets.
//   A packet holds NUM_CHUNKS chunks, chunk 0 most significant, each {tag, CW bits}.
// Ports:
//   i_word     in   word to be framed with data tags
//   i_packet   in   received packet to be unframed and tag-checked
//   o_packet   out  framed i_word
//   o_payload  out  i_packet with tags stripped
//   o_data_ok  out  i_packet carries the data tag pattern
//   o_hdr_ok   out  i_packet carries the header tag pattern
`timescale 1ns/1ps
module memif_packet_codec
  import memif_pkg::*;
#(
  parameter int WORD_WIDTH = 36,
  parameter int NUM_CHUNKS = 2,
  localparam int CW = WORD_WIDTH / NUM_CHUNKS,
  localparam int PACKET_WIDTH = WORD_WIDTH + 2 * NUM_CHUNKS
) (
  input  logic [WORD_WIDTH-1:0]   i_word,
  input  logic [PACKET_WIDTH-1:0] i_packet,
  output logic [PACKET_WIDTH-1:0] o_packet,
  output logic [WORD_WIDTH-1:0]   o_payload,
  output logic                    o_data_ok,
  output logic                    o_hdr_ok
);

  logic [NUM_CHUNKS-1:0] w_data_tag_ok;
  logic [NUM_CHUNKS-1:0] w_hdr_tag_ok;

  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
      // Chunk gi sits at these offsets in the packet and in the word.
      localparam int PLSB = (NUM_CHUNKS - 1 - gi) * (CW + 2);
      localparam int WLSB = (NUM_CHUNKS - 1 - gi) * CW;
      localparam logic [1:0] DATA_TAG = (gi == 0) ? TAG_FIRST : TAG_REST;
      localparam logic [1:0] HDR_TAG  = (gi == 0) ? TAG_HDR : TAG_REST;

      logic [1:0] w_tag;

      assign o_packet[PLSB +: CW+2]  = {DATA_TAG, i_word[WLSB +: CW]};
      assign o_payload[WLSB +: CW]   = i_packet[PLSB +: CW];
      assign w_tag                   = i_packet[PLSB+CW +: 2];
      assign w_data_tag_ok[gi]       = (w_tag == DATA_TAG);
      assign w_hdr_tag_ok[gi]        = (w_tag == HDR_TAG);
    end
  endgenerate

  assign o_data_ok = &w_data_tag_ok;
  assign o_hdr_ok  = &w_hdr_tag_ok;

endmodule

// File: rtl/memif_stream.sv
// memif_stream: bridge between a packet serdes and a word-wide parameter memory.
//   Each frame starts with a status reply (error count); the host's first packet is a
//   header (start address, write mode), then data packets stream reads/writes at
//   auto-incrementing, DEPTH-wrapping addresses.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   frame_start         chip-select pulse, restarts the frame
//   in_word, in_valid   received packet and its strobe
//   out_word, out_load  packet to transmit and its load strobe
//   rd_addr, rd_data    memory read port (one cycle read latency)
//   wr_addr, wr_data, wr_en  memory write port
//   frame_active        controller is inside a frame
//   last_valid          tag check result of the latest data packet
//   err_count           saturating framing/protocol error count
`timescale 1ns/1ps
module memif_stream
  import memif_pkg::*;
#(
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int NUM_CHUNKS = 2,
  parameter int ERR_WIDTH  = 8,
  localparam int PACKET_WIDTH = WORD_WIDTH + 2 * NUM_CHUNKS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [PACKET_WIDTH-1:0] in_word,
  input  logic                    in_valid,
  output logic [PACKET_WIDTH-1:0] out_word,
  output logic                    out_load,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [WORD_WIDTH-1:0]   rd_data,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [WORD_WIDTH-1:0]   wr_data,
  output logic                    wr_en,
  output logic                    frame_active,
  output logic                    last_valid,
  output logic [ERR_WIDTH-1:0]    err_count
);

  state_t                  r_state;
  logic                    r_wr_mode;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [PACKET_WIDTH-1:0] r_out_word;
  logic                    r_out_load;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [WORD_WIDTH-1:0]   r_wr_data;
  logic                    r_wr_en;
  logic                    r_last_valid;
  logic [ERR_WIDTH-1:0]    r_err;

  logic [WORD_WIDTH-1:0]   w_frame_src;
  logic [PACKET_WIDTH-1:0] w_framed;
  logic [WORD_WIDTH-1:0]   w_payload;
  logic                    w_data_ok;
  logic                    w_hdr_ok;
  logic [ERR_WIDTH-1:0]    w_err_inc;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // One framer serves both replies: the status word on frame_start, memory data otherwise.
  assign w_frame_src = frame_start ? WORD_WIDTH'(r_err) : rd_data;
  assign w_err_inc   = (&r_err) ? r_err : r_err + 1'b1;

  memif_packet_codec #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_CHUNKS (NUM_CHUNKS)
  ) u_codec (
    .i_word    (w_frame_src),
    .i_packet  (in_word),
    .o_packet  (w_framed),
    .o_payload (w_payload),
    .o_data_ok (w_data_ok),
    .o_hdr_ok  (w_hdr_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wr_mode    <= 1'b0;
      r_wr_ptr     <= '0;
      r_out_word   <= '0;
      r_out_load   <= 1'b0;
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_en      <= 1'b0;
      r_last_valid <= 1'b0;
      r_err        <= '0;
    end else begin
      r_out_load <= 1'b0;
      r_wr_en    <= 1'b0;
      if (frame_start) begin
        // Restart from any state; a coincident packet is discarded.
        r_out_word <= w_framed;
        r_out_load <= 1'b1;
        r_state    <= HDR;
      end else begin
        case (r_state)
          HDR: begin
            if (in_valid) begin
              if (w_hdr_ok) begin
                r_wr_mode <= w_payload[WORD_WIDTH-1];
                r_rd_addr <= w_payload[ADDR_WIDTH-1:0];
                r_wr_addr <= w_payload[ADDR_WIDTH-1:0];
                r_wr_ptr  <= w_payload[ADDR_WIDTH-1:0];
                r_state   <= FETCH;
              end else begin
                r_err   <= w_err_inc;
                r_state <= IDLE;
              end
            end
          end
          FETCH: begin
            // Memory read of the start address is in flight.
            if (in_valid) r_err <= w_err_inc;
            r_state <= LOAD;
          end
          LOAD: begin
            if (in_valid) r_err <= w_err_inc;
            r_out_word <= w_framed;
            r_out_load <= 1'b1;
            r_rd_addr  <= addr_inc(r_rd_addr);
            r_state    <= STREAM;
          end
          STREAM: begin
            if (in_valid) begin
              r_out_word   <= w_framed;
              r_out_load   <= 1'b1;
              r_rd_addr    <= addr_inc(r_rd_addr);
              r_last_valid <= w_data_ok;
              if (w_data_ok && r_wr_mode) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= w_payload;
                r_wr_addr <= r_wr_ptr;
              end else if (!w_data_ok) begin
                r_err <= w_err_inc;
              end
              // Advance even on a bad packet so later words land where the host expects.
              r_wr_ptr <= addr_inc(r_wr_ptr);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_word     = r_out_word;
  assign out_load     = r_out_load;
  assign rd_addr      = r_rd_addr;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign wr_en        = r_wr_en;
  assign last_valid   = r_last_valid;
  assign err_count    = r_err;
  assign frame_active = (r_state != IDLE);

endmodule
